// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer memory subsystem.
//
// Holds the default VRAM word address/data widths, the framebuffer
// geometry they were sized for, and the enumerations used by the VRAM
// arbiter. It has no ports; modules pull it in with import vga_pkg::*.
package vga_pkg;

  // Default framebuffer word address and data widths.
  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;

  // Framebuffer geometry: one 8-bit word per pixel. 160x120 = 19200 words,
  // which fits in the 2^15-word address space above.
  localparam int FB_H_PIXELS = 160;
  localparam int FB_V_LINES  = 120;
  localparam int FB_WORDS    = FB_H_PIXELS * FB_V_LINES;

  // Which requester owns the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_DISP  = 2'd1,
    OWN_READ  = 2'd2,
    OWN_WRITE = 2'd3
  } ram_owner_e;

  // Host read request tracking: a read is either absent or accepted and
  // waiting for a cycle in which the display leaves the RAM port free.
  typedef enum logic {
    RD_IDLE    = 1'b0,
    RD_PENDING = 1'b1
  } rd_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding host writes (address+data) waiting for the RAM.
//
// Ports:
//   clk_i      - clock, all logic on the rising edge
//   reset_n_i  - synchronous active-low reset, empties the queue
//   push_i     - enqueue wdata_i (ignored when full)
//   wdata_i    - entry to enqueue
//   pop_i      - dequeue the head (ignored when empty)
//   rdata_o    - current head entry (valid when !empty_o)
//   level_o    - number of stored entries, 0..DEPTH
//   full_o     - level_o == DEPTH
//   empty_o    - level_o == 0
//
// DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally. Storage is not reset; only the pointers and level are.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push is refused when full even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port RAM (1-cycle registered read)
// between display scan-out, host reads and queued host writes.
//
// Ports:
//   clk, reset_n                    - clock, synchronous active-low reset
//   disp_req, disp_addr             - display read request; always granted
//   disp_data, disp_data_valid      - display read return, 1 cycle later
//   host_wr_valid/_ready/_addr/_data - host write channel into the queue
//   host_rd_req/_ready, host_rd_addr - host read request channel
//   host_rd_data, host_rd_valid     - host read return (data holds)
//   ram_we, ram_addr, ram_wdata     - RAM command, driven combinationally
//   ram_rdata                       - RAM read data, 1 cycle after address
//   wr_level                        - write queue occupancy
//   dbg_owner_o                     - current RAM owner (ram_owner_e)
//   dbg_rd_state_o                  - host read tracker state (rd_state_e)
//
// Handshakes: a host write transfers on a cycle where host_wr_valid and
// host_wr_ready are both high, except that a host read accepted in the same
// cycle wins and the write is not taken (the host must hold it). A host read
// transfers on host_rd_req && host_rd_ready. The ready signals depend only
// on registered state and reset_n, never on the requester's own valid.
//
// RAM priority each cycle: display > host read > write queue head > idle.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_rd_req,
  output logic              host_rd_ready,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  output logic              host_rd_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [LVL_W-1:0]  wr_level,
  output logic [1:0]        dbg_owner_o,
  output logic              dbg_rd_state_o
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  rd_state_e         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  ram_owner_e        owner;

  logic               rd_accept;
  logic               wr_push;
  logic               wr_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  logic              disp_valid_q;
  logic              host_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic [DATA_W-1:0] host_data_q;

  // Reads are only taken with the queue empty so a read can never overtake
  // a queued write to the same address.
  assign host_rd_ready = reset_n && fifo_empty && (rd_state_q == RD_IDLE);
  assign host_wr_ready = reset_n && !fifo_full && (rd_state_q == RD_IDLE);
  assign rd_accept     = host_rd_req && host_rd_ready;
  assign wr_push       = host_wr_valid && host_wr_ready && !rd_accept;
  assign wr_pop        = (owner == OWN_WRITE);

  assign {head_addr, head_data} = fifo_head;

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .push_i    (wr_push),
    .wdata_i   ({host_wr_addr, host_wr_data}),
    .pop_i     (wr_pop),
    .rdata_o   (fifo_head),
    .level_o   (wr_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Port ownership. A freshly accepted read may issue in its accept cycle.
  // Nothing owns the port while reset_n is low, so no write slips through.
  always_comb begin
    owner = OWN_IDLE;
    if (reset_n) begin
      if (disp_req)                                 owner = OWN_DISP;
      else if (rd_state_q == RD_PENDING || rd_accept) owner = OWN_READ;
      else if (!fifo_empty)                         owner = OWN_WRITE;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (owner)
      OWN_DISP:  ram_addr = disp_addr;
      OWN_READ:  ram_addr = (rd_state_q == RD_PENDING) ? rd_addr_q : host_rd_addr;
      OWN_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = head_addr;
        ram_wdata = head_data;
      end
      default: ;
    endcase
  end

  // Host read tracker: park the address only if the display holds the port.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_accept && owner != OWN_READ) begin
          rd_state_d = RD_PENDING;
          rd_addr_d  = host_rd_addr;
        end
      end
      RD_PENDING: begin
        if (owner == OWN_READ) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Return path. The RAM presents data the cycle after the address, so the
  // valid flags are the owner delayed by one; data is passed straight from
  // ram_rdata in the valid cycle and held in a register afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_valid_q <= 1'b0;
      host_valid_q <= 1'b0;
      disp_data_q  <= '0;
      host_data_q  <= '0;
    end else begin
      disp_valid_q <= (owner == OWN_DISP);
      host_valid_q <= (owner == OWN_READ);
      if (disp_valid_q) disp_data_q <= ram_rdata;
      if (host_valid_q) host_data_q <= ram_rdata;
    end
  end

  assign disp_data_valid = disp_valid_q;
  assign disp_data       = disp_valid_q ? ram_rdata : disp_data_q;
  assign host_rd_valid   = host_valid_q;
  assign host_rd_data    = host_valid_q ? ram_rdata : host_data_q;

  assign dbg_owner_o    = owner;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a random
// run, all compared against a queue-based behavioural model of the arbiter
// and a separate RAM model attached to the DUT's RAM port.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int OP_IDLE  = 0;
  localparam int OP_DISP  = 1;
  localparam int OP_READ  = 2;
  localparam int OP_WRITE = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_data_valid;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          host_rd_req;
  logic          host_rd_ready;
  logic [AW-1:0] host_rd_addr;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_valid;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [LW-1:0] wr_level;
  logic [1:0]    dbg_owner;
  logic          dbg_rd_state;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .disp_req        (disp_req),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .disp_data_valid (disp_data_valid),
    .host_wr_valid   (host_wr_valid),
    .host_wr_ready   (host_wr_ready),
    .host_wr_addr    (host_wr_addr),
    .host_wr_data    (host_wr_data),
    .host_rd_req     (host_rd_req),
    .host_rd_ready   (host_rd_ready),
    .host_rd_addr    (host_rd_addr),
    .host_rd_data    (host_rd_data),
    .host_rd_valid   (host_rd_valid),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .wr_level        (wr_level),
    .dbg_owner_o     (dbg_owner),
    .dbg_rd_state_o  (dbg_rd_state)
  );

  int checks = 0;
  int errors = 0;

  // Power-up framebuffer contents, shared by the RAM and the model.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  // ---------------------------------------------------------------- RAM model
  logic [DW-1:0] env_mem [int];
  always @(posedge clk) begin
    ram_rdata <= env_mem.exists(int'(ram_addr)) ? env_mem[int'(ram_addr)] : init_val(ram_addr);
    if (ram_we) env_mem[int'(ram_addr)] = ram_wdata;
  end

  // ---------------------------------------------------------------- reference model
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           m_wq[$];
  logic          m_rd_pend = 1'b0;
  logic [AW-1:0] m_rd_addr = '0;
  logic [DW-1:0] m_mem [int];
  logic          m_disp_ret = 1'b0;
  logic [DW-1:0] m_disp_val = '0;
  logic          m_rd_ret = 1'b0;
  logic [DW-1:0] m_rd_hold = '0;
  logic [DW-1:0] exp_q[$];   // expected host read return data, in order

  logic          e_we, e_wr_ready, e_rd_ready, e_acc, e_push;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int            e_level, e_op;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_val(a);
  endfunction

  // Expected behaviour for the current cycle from the priority rules.
  task automatic model_eval();
    e_wr_ready = reset_n && (m_wq.size() < DEPTH) && !m_rd_pend;
    e_rd_ready = reset_n && (m_wq.size() == 0) && !m_rd_pend;
    e_acc      = host_rd_req && e_rd_ready;
    e_push     = host_wr_valid && e_wr_ready && !e_acc;
    e_level    = m_wq.size();
    e_op = OP_IDLE; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (reset_n) begin
      if (disp_req) begin
        e_op = OP_DISP; e_addr = disp_addr;
      end else if (m_rd_pend) begin
        e_op = OP_READ; e_addr = m_rd_addr;
      end else if (e_acc) begin
        e_op = OP_READ; e_addr = host_rd_addr;
      end else if (m_wq.size() > 0) begin
        e_op = OP_WRITE; e_we = 1'b1; e_addr = m_wq[0].a; e_wdata = m_wq[0].d;
      end
    end
  endtask

  // Apply the clock edge to the model.
  task automatic model_commit();
    wr_t w;
    if (!reset_n) begin
      m_wq.delete(); exp_q.delete();
      m_rd_pend = 1'b0; m_disp_ret = 1'b0; m_rd_ret = 1'b0;
      m_disp_val = '0; m_rd_hold = '0;
      return;
    end
    if (m_rd_ret && exp_q.size() > 0) m_rd_hold = exp_q.pop_front();
    m_disp_ret = (e_op == OP_DISP);
    if (e_op == OP_DISP) m_disp_val = mem_rd(e_addr);
    m_rd_ret = (e_op == OP_READ);
    if (e_op == OP_READ) exp_q.push_back(mem_rd(e_addr));
    if (e_op == OP_WRITE) begin
      m_mem[int'(e_addr)] = e_wdata;
      void'(m_wq.pop_front());
    end
    if (e_op == OP_READ) m_rd_pend = 1'b0;
    else if (e_acc) begin
      m_rd_pend = 1'b1; m_rd_addr = host_rd_addr;
    end
    if (e_push) begin
      w.a = host_wr_addr; w.d = host_wr_data;
      m_wq.push_back(w);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic idle_inputs();
    reset_n = 1'b1; disp_req = 1'b0; disp_addr = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_req = 1'b0; host_rd_addr = '0;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle_inputs();
    repeat (8) begin settle(); advance(); end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0; host_wr_valid = 1'b1; host_rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (host_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready cyc %0d: got %b expected 0", c, host_wr_ready); end
      checks++; if (host_rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready cyc %0d: got %b expected 0", c, host_rd_ready); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we cyc %0d: got %b expected 0", c, ram_we); end
      advance();
    end
    idle_inputs();
    settle();
    checks++;
    if (wr_level !== '0 || disp_data_valid !== 1'b0 || host_rd_valid !== 1'b0 || disp_data !== '0 ||
        host_rd_data !== '0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got lvl=%0d dv=%b hv=%b dd=%h hd=%h we=%b addr=%h wd=%h expected all 0",
               wr_level, disp_data_valid, host_rd_valid, disp_data, host_rd_data, ram_we, ram_addr, ram_wdata);
    end
    checks++; if (host_wr_ready !== 1'b1 || host_rd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got wr=%b rd=%b expected 1 1", host_wr_ready, host_rd_ready); end
    advance();
  endtask

  task automatic test_display_latency();
    idle_inputs();
    host_wr_valid = 1'b1; host_wr_addr = AW'(16'h0042); host_wr_data = 8'h3C;
    settle(); advance();
    idle_inputs();
    settle(); advance();
    disp_req = 1'b1; disp_addr = AW'(16'h0042);
    settle();
    checks++; if (ram_addr !== AW'(16'h0042) || ram_we !== 1'b0) begin errors++; $display("FAIL lat_grant: got addr=%h we=%b expected 0042 0", ram_addr, ram_we); end
    checks++; if (disp_data_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_n: got %b expected 0", disp_data_valid); end
    advance();
    idle_inputs();
    settle();
    checks++; if (disp_data_valid !== 1'b1 || disp_data !== 8'h3C) begin errors++; $display("FAIL lat_return: got v=%b d=%h expected 1 3c", disp_data_valid, disp_data); end
    advance();
    settle();
    checks++; if (disp_data_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_n2: got %b expected 0", disp_data_valid); end
    advance();
  endtask

  task automatic test_display_priority();
    logic [DW-1:0] wd [3];
    for (int i = 0; i < 3; i++) wd[i] = DW'($urandom_range(0, 255));
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      disp_req = 1'b1; disp_addr = AW'($urandom_range(0, 1023));
      host_wr_valid = (c < 3);
      host_wr_addr = AW'(16'h0200 + c);
      host_wr_data = (c < 3) ? wd[c] : '0;
      settle();
      checks++; if (ram_we !== 1'b0 || ram_addr !== disp_addr) begin errors++; $display("FAIL prio_disp_own cyc %0d: got we=%b addr=%h expected 0 %h", c, ram_we, ram_addr, disp_addr); end
      if (c >= 1) begin
        checks++; if (disp_data_valid !== 1'b1 || disp_data !== m_disp_val) begin errors++; $display("FAIL prio_disp_ret cyc %0d: got v=%b d=%h expected 1 %h", c, disp_data_valid, disp_data, m_disp_val); end
      end
      if (c == 9) begin
        checks++; if (wr_level !== LW'(3)) begin errors++; $display("FAIL prio_level: got %0d expected 3", wr_level); end
      end
      advance();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== AW'(16'h0200 + k) || ram_wdata !== wd[k]) begin
        errors++;
        $display("FAIL prio_drain %0d: got we=%b addr=%h wd=%h expected 1 %h %h", k, ram_we, ram_addr, ram_wdata, AW'(16'h0200 + k), wd[k]);
      end
      advance();
    end
    settle();
    checks++; if (wr_level !== '0 || ram_we !== 1'b0) begin errors++; $display("FAIL prio_empty: got lvl=%0d we=%b expected 0 0", wr_level, ram_we); end
    advance();
  endtask

  task automatic test_queue_full();
    logic exp_rdy;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      disp_req = 1'b1; disp_addr = AW'(c);
      host_wr_valid = 1'b1; host_wr_addr = AW'(16'h0300 + c); host_wr_data = DW'($urandom_range(0, 255));
      settle();
      exp_rdy = (c < 4);
      checks++; if (host_wr_ready !== exp_rdy) begin errors++; $display("FAIL full_ready cyc %0d: got %b expected %b", c, host_wr_ready, exp_rdy); end
      advance();
    end
    idle_inputs();
    disp_req = 1'b1;
    settle();
    checks++; if (wr_level !== LW'(4)) begin errors++; $display("FAIL full_level: got %0d expected 4", wr_level); end
    advance();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(16'h0300 + k) || ram_wdata !== e_wdata) begin errors++; $display("FAIL full_drain %0d: got we=%b addr=%h wd=%h expected 1 %h %h", k, ram_we, ram_addr, ram_wdata, AW'(16'h0300 + k), e_wdata); end
      advance();
    end
    settle();
    checks++; if (ram_we !== 1'b0 || wr_level !== '0) begin errors++; $display("FAIL full_no_fifth: got we=%b lvl=%0d expected 0 0", ram_we, wr_level); end
    advance();
  endtask

  task automatic test_read_after_write();
    idle_inputs();
    host_wr_valid = 1'b1; host_wr_addr = AW'(16'h0100); host_wr_data = 8'hA5;
    settle();
    checks++; if (host_wr_ready !== 1'b1) begin errors++; $display("FAIL raw_wr_ready: got %b expected 1", host_wr_ready); end
    advance();
    idle_inputs();
    host_rd_req = 1'b1; host_rd_addr = AW'(16'h0100);
    settle();
    checks++; if (host_rd_ready !== 1'b0) begin errors++; $display("FAIL raw_rd_blocked: got %b expected 0", host_rd_ready); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== AW'(16'h0100) || ram_wdata !== 8'hA5) begin errors++; $display("FAIL raw_write: got we=%b addr=%h wd=%h expected 1 0100 a5", ram_we, ram_addr, ram_wdata); end
    advance();
    settle();
    checks++; if (host_rd_ready !== 1'b1) begin errors++; $display("FAIL raw_rd_ready: got %b expected 1", host_rd_ready); end
    checks++; if (ram_we !== 1'b0 || ram_addr !== AW'(16'h0100)) begin errors++; $display("FAIL raw_issue: got we=%b addr=%h expected 0 0100", ram_we, ram_addr); end
    advance();
    idle_inputs();
    settle();
    checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== 8'hA5) begin errors++; $display("FAIL raw_return: got v=%b d=%h expected 1 a5", host_rd_valid, host_rd_data); end
    advance();
    settle();
    checks++; if (host_rd_valid !== 1'b0 || host_rd_data !== 8'hA5) begin errors++; $display("FAIL raw_hold: got v=%b d=%h expected 0 a5", host_rd_valid, host_rd_data); end
    advance();
  endtask

  task automatic test_read_during_display();
    logic [AW-1:0] raddr;
    logic [DW-1:0] rexp;
    raddr = AW'(16'h0400 + $urandom_range(0, 63));
    rexp  = mem_rd(raddr);
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      disp_req = (c <= 3); disp_addr = AW'(16'h0500 + c);
      host_rd_req = (c == 0); host_rd_addr = raddr;
      settle();
      if (c == 0) begin
        checks++; if (host_rd_ready !== 1'b1) begin errors++; $display("FAIL rdd_accept: got %b expected 1", host_rd_ready); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (host_rd_ready !== 1'b0 || host_wr_ready !== 1'b0) begin errors++; $display("FAIL rdd_pending_ready cyc %0d: got rd=%b wr=%b expected 0 0", c, host_rd_ready, host_wr_ready); end
      end
      if (c <= 3) begin
        checks++; if (ram_we !== 1'b0 || ram_addr !== disp_addr) begin errors++; $display("FAIL rdd_disp_own cyc %0d: got we=%b addr=%h expected 0 %h", c, ram_we, ram_addr, disp_addr); end
      end
      if (c == 4) begin
        checks++; if (ram_we !== 1'b0 || ram_addr !== raddr || host_rd_valid !== 1'b0) begin errors++; $display("FAIL rdd_issue: got we=%b addr=%h hv=%b expected 0 %h 0", ram_we, ram_addr, host_rd_valid, raddr); end
      end
      if (c == 5) begin
        checks++; if (host_rd_valid !== 1'b1 || host_rd_data !== rexp) begin errors++; $display("FAIL rdd_return: got v=%b d=%h expected 1 %h", host_rd_valid, host_rd_data, rexp); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      disp_req = 1'b1; disp_addr = AW'(c);
      host_wr_valid = 1'b1; host_wr_addr = AW'(16'h0600 + c); host_wr_data = DW'($urandom_range(0, 255));
      settle(); advance();
    end
    idle_inputs();
    reset_n = 1'b0;
    settle();
    checks++; if (wr_level !== LW'(3)) begin errors++; $display("FAIL mid_level_before: got %0d expected 3", wr_level); end
    checks++; if (ram_we !== 1'b0 || host_wr_ready !== 1'b0 || host_rd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_cycle: got we=%b wr=%b rd=%b expected 0 0 0", ram_we, host_wr_ready, host_rd_ready); end
    advance();
    idle_inputs();
    settle();
    checks++;
    if (wr_level !== '0 || ram_we !== 1'b0 || ram_addr !== '0 || disp_data_valid !== 1'b0 ||
        host_rd_valid !== 1'b0 || disp_data !== '0 || host_rd_data !== '0) begin
      errors++;
      $display("FAIL mid_after: got lvl=%0d we=%b addr=%h dv=%b hv=%b dd=%h hd=%h expected all 0",
               wr_level, ram_we, ram_addr, disp_data_valid, host_rd_valid, disp_data, host_rd_data);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL mid_discard cyc %0d: got we=%b expected 0", c, ram_we); end
      advance();
    end
    for (int c = 0; c < 3; c++) begin
      checks++; if (env_mem.exists(16'h0600 + c)) begin errors++; $display("FAIL mid_ram_written %0d: got written expected untouched", c); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      disp_req      = ($urandom_range(0, 99) < 35);
      disp_addr     = AW'($urandom_range(0, 63));
      host_wr_valid = ($urandom_range(0, 1) == 1);
      host_wr_addr  = AW'($urandom_range(0, 63));
      host_wr_data  = DW'($urandom_range(0, 255));
      host_rd_req   = ($urandom_range(0, 99) < 25);
      host_rd_addr  = AW'($urandom_range(0, 63));
      settle();
      checks++;
      if (ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_wdata !== e_wdata) ||
          host_wr_ready !== e_wr_ready || host_rd_ready !== e_rd_ready || wr_level !== LW'(e_level) ||
          disp_data_valid !== m_disp_ret || host_rd_valid !== m_rd_ret) begin
        errors++;
        $display("FAIL rand_ctrl cyc %0d: got we=%b addr=%h wd=%h wrdy=%b rrdy=%b lvl=%0d dv=%b hv=%b own=%0d expected we=%b addr=%h wd=%h wrdy=%b rrdy=%b lvl=%0d dv=%b hv=%b op=%0d",
                 c, ram_we, ram_addr, ram_wdata, host_wr_ready, host_rd_ready, wr_level, disp_data_valid, host_rd_valid, dbg_owner,
                 e_we, e_addr, e_wdata, e_wr_ready, e_rd_ready, e_level, m_disp_ret, m_rd_ret, e_op);
      end
      if (m_disp_ret) begin
        checks++; if (disp_data !== m_disp_val) begin errors++; $display("FAIL rand_disp_data cyc %0d: got %h expected %h", c, disp_data, m_disp_val); end
      end
      if (m_rd_ret) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_host_data cyc %0d: got %h expected none queued", c, host_rd_data); end
        else if (host_rd_data !== exp_q[0]) begin errors++; $display("FAIL rand_host_data cyc %0d: got %h expected %h", c, host_rd_data, exp_q[0]); end
      end else begin
        checks++; if (host_rd_data !== m_rd_hold) begin errors++; $display("FAIL rand_host_hold cyc %0d: got %h expected %h (rd_state=%b)", c, host_rd_data, m_rd_hold, dbg_rd_state); end
      end
      advance();
    end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    idle_inputs();
    reset_n = 1'b0;
    test_reset();
    flush(); test_display_latency();
    flush(); test_display_priority();
    flush(); test_queue_full();
    flush(); test_read_after_write();
    flush(); test_read_during_display();
    flush(); test_reset_mid_drain();
    flush(); test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
